// File: rtl/mcu_bus_regs.sv
// -----------------------------------------------------------------------------
// mcu_bus_regs
//   Slave for the MCU multiplexed ALE/RD/WR parallel bus. The asynchronous
//   strobes and the bus pins are synchronised. The address is latched during
//   ALE. Writes are committed into a bank of NUM_REGS registers. Reads are
//   served from per-register status inputs. The pad tristate is built in the
//   top level from bus_out/bus_oe.
//
// Optional feature (macro MCU_BUS_TIMEOUT_EN):
//   When defined, a strobe or ALE that stays low for TIMEOUT cycles aborts the
//   transaction. The abort raises bus_err, drops bus_oe and discards any
//   pending write. When undefined, a stuck strobe holds the state machine
//   indefinitely.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   ale_n      address latch enable, active low (asynchronous pin)
//   rd_n       read strobe, active low (asynchronous pin)
//   wr_n       write strobe, active low (asynchronous pin)
//   bus_in     bus pins as sampled from the pad
//   bus_out    read data to drive onto the bus
//   bus_oe     drive enable for bus_out
//   reg_q      register bank contents; reg i is at [i*DATA_W +: DATA_W]
//   status_in  read-back value per register, same packing as reg_q
//   wr_stb     one-cycle pulse on the register just written
//   rd_stb     one-cycle pulse when a register read completes
//   bus_err    one-cycle pulse on a protocol violation or timeout
// -----------------------------------------------------------------------------
module mcu_bus_regs #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ale_n,
  input  logic                         rd_n,
  input  logic                         wr_n,
  input  logic [DATA_W-1:0]            bus_in,
  output logic [DATA_W-1:0]            bus_out,
  output logic                         bus_oe,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   status_in,
  output logic [NUM_REGS-1:0]          wr_stb,
  output logic [NUM_REGS-1:0]          rd_stb,
  output logic                         bus_err
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [DATA_W:0] BASE_EXT = (DATA_W+1)'(BASE_ADDR);
  localparam logic [DATA_W:0] NUM_EXT  = (DATA_W+1)'(NUM_REGS);

  // Reject configurations the logic below cannot honour.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("mcu_bus_regs: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mcu_bus_regs: TIMEOUT must be at least 1");
  end
  if (NUM_REGS < 1 || 64'(NUM_REGS) > (64'd1 << DATA_W)) begin : g_bad_regs
    $error("mcu_bus_regs: NUM_REGS must be in 1..2^DATA_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE,
    ST_READ
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers. Every pin gets the same depth, so the data on bus_s stays
  // aligned with the strobe it belongs to.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ale_sr, rd_sr, wr_sr;
  logic [DATA_W-1:0]      bus_sr [SYNC_STAGES];

  // NOTE: the strobe synchronisers reset to the idle (high) level. If they
  // reset to zero, reset release would look like a falling strobe and start a
  // phantom transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ale_sr <= '1;
      rd_sr  <= '1;
      wr_sr  <= '1;
      for (int i = 0; i < int'(SYNC_STAGES); i++) bus_sr[i] <= '0;
    end else begin
      ale_sr    <= {ale_sr[SYNC_STAGES-2:0], ale_n};
      rd_sr     <= {rd_sr[SYNC_STAGES-2:0],  rd_n};
      wr_sr     <= {wr_sr[SYNC_STAGES-2:0],  wr_n};
      bus_sr[0] <= bus_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) bus_sr[i] <= bus_sr[i-1];
    end
  end

  logic              ale_s, rd_s, wr_s;
  logic [DATA_W-1:0] bus_s;
  assign ale_s = ale_sr[SYNC_STAGES-1];
  assign rd_s  = rd_sr[SYNC_STAGES-1];
  assign wr_s  = wr_sr[SYNC_STAGES-1];
  assign bus_s = bus_sr[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // State, address/data holding and the register bank
  // ---------------------------------------------------------------------------
  state_t            state;
  logic              armed;      // IDLE accepts a new phase only when set
  logic [DATA_W-1:0] addr_hold;
  logic [DATA_W-1:0] data_hold;
  logic [DATA_W-1:0] regs [NUM_REGS];

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_pack
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  // Address decode. The subtraction is one bit wider than the bus, so an
  // address below BASE_ADDR borrows into the top bit and counts as a miss.
  logic [DATA_W:0]  addr_off;
  logic             hit;
  logic [IDX_W-1:0] idx;

  // NOTE: every signal assigned in this block gets a value on every path
  // (defaults first). A missing default would infer a latch.
  always_comb begin
    addr_off = {1'b0, addr_hold} - BASE_EXT;
    hit      = !addr_off[DATA_W] && (addr_off < NUM_EXT);
    idx      = addr_off[IDX_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Abort conditions: both strobes low, ALE inside a data phase, or timeout.
  // An IDLE that is not yet re-armed ignores them, so a single violation
  // raises exactly one bus_err pulse.
  // ---------------------------------------------------------------------------
  logic tmo_hit;

`ifdef MCU_BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // The counter restarts every time the machine sits in IDLE. It therefore
  // measures how long the current ADDR/READ/WRITE phase has been open.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (state == ST_IDLE || tmo_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT));
`else
  assign tmo_hit = 1'b0;
`endif

  logic proto_err;
  logic abort;

  always_comb begin
    proto_err = (!rd_s && !wr_s) ||
                (!ale_s && (state == ST_READ || state == ST_WRITE));
    abort     = ((state != ST_IDLE) || armed) && (proto_err || tmo_hit);
  end

  // ---------------------------------------------------------------------------
  // Bus state machine with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: the register bank is built from flops, not RAM. Its reset therefore
  // clears every entry asynchronously, just as it does the other outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      armed     <= 1'b1;
      addr_hold <= '0;
      data_hold <= '0;
      bus_out   <= '0;
      bus_oe    <= 1'b0;
      wr_stb    <= '0;
      rd_stb    <= '0;
      bus_err   <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      wr_stb  <= '0;
      rd_stb  <= '0;
      bus_err <= 1'b0;

      if (abort) begin
        bus_err <= 1'b1;
        bus_oe  <= 1'b0;
        state   <= ST_IDLE;
        armed   <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            // Phases are entered on the level. That is equivalent to the
            // falling edge because IDLE is only armed with all strobes high.
            // Using the level also lets a strobe that falls right after the
            // previous one rises start a new phase with no gap.
            if (!armed) begin
              if (ale_s && rd_s && wr_s) armed <= 1'b1;
            end else if (!ale_s) begin
              state     <= ST_ADDR;
              addr_hold <= bus_s;
            end else if (!wr_s) begin
              state     <= ST_WRITE;
              data_hold <= bus_s;
            end else if (!rd_s) begin
              state <= ST_READ;
              if (hit) begin
                // The snapshot holds still for the whole strobe, even if
                // status_in changes meanwhile.
                bus_out <= status_in[idx*DATA_W +: DATA_W];
                bus_oe  <= 1'b1;
              end
            end
          end

          ST_ADDR: begin
            // The bus data is gone once ALE releases, so addr_hold freezes
            // on the last sample taken while ALE was low.
            if (ale_s) state     <= ST_IDLE;
            else       addr_hold <= bus_s;
          end

          ST_WRITE: begin
            if (wr_s) begin
              state <= ST_IDLE;
              if (hit) begin
                regs[idx]   <= data_hold;
                wr_stb[idx] <= 1'b1;
              end
            end else begin
              data_hold <= bus_s;
            end
          end

          ST_READ: begin
            if (rd_s) begin
              state  <= ST_IDLE;
              bus_oe <= 1'b0;
              if (hit) rd_stb[idx] <= 1'b1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu_bus_regs.sv
// -----------------------------------------------------------------------------
// tb_mcu_bus_regs
//   Scoreboard bench for mcu_bus_regs. Each bus task pushes the strobe it
//   expects, with its register index and data. A negedge monitor pops that
//   entry when wr_stb/rd_stb fires and compares it. The monitor also counts
//   bus_oe cycles, bus_err pulses and strobe pulses, and the tasks check
//   those counts after each transaction.
// -----------------------------------------------------------------------------
module tb_mcu_bus_regs;

  localparam int DW = 8;
  localparam int NR = 16;
  localparam int BA = 'h10;
  localparam int SS = 2;
  localparam int TO = 20;
  localparam int CW = NR * DW;

  logic          clk;
  logic          reset_n;
  logic          ale_n, rd_n, wr_n;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic [CW-1:0] reg_q;
  logic [CW-1:0] status_in;
  logic [NR-1:0] wr_stb, rd_stb;
  logic          bus_err;

  mcu_bus_regs #(
    .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR(BA), .SYNC_STAGES(SS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ale_n(ale_n), .rd_n(rd_n), .wr_n(wr_n),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .reg_q(reg_q),
    .status_in(status_in), .wr_stb(wr_stb), .rd_stb(rd_stb), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #34 clk = ~clk;   // 68 ns period

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [CW-1:0] obs,
                       input logic [CW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit            is_rd;
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_regs [NR];

  function automatic logic [DW-1:0] stat_val(input int i);
    return (i == 2) ? 8'h5A : DW'(8'hA0 + i);
  endfunction

  function automatic logic [CW-1:0] model_pack();
    logic [CW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*DW +: DW] = model_regs[i];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int            oe_cycles  = 0;
  int            err_pulses = 0;
  int            wr_pulses  = 0;
  int            rd_pulses  = 0;
  logic [DW-1:0] last_out   = '0;
  logic [NR-1:0] prev_wr    = '0;
  logic [NR-1:0] prev_rd    = '0;

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus_oe) begin
        oe_cycles++;
        last_out = bus_out;
      end
      if (bus_err) err_pulses++;
      if (wr_stb != '0) begin
        wr_pulses++;
        check("wr_stb_len", CW'(prev_wr), '0);
        if (sb.size() == 0) check("wr_unexpected", CW'(wr_stb), '0);
        else begin
          e = sb.pop_front();
          check("wr_kind", CW'(e.is_rd), '0);
          check("wr_stb", CW'(wr_stb), CW'(1) << e.idx);
          check("wr_reg", CW'(reg_q[e.idx*DW +: DW]), CW'(e.data));
        end
      end
      if (rd_stb != '0) begin
        rd_pulses++;
        check("rd_stb_len", CW'(prev_rd), '0);
        if (sb.size() == 0) check("rd_unexpected", CW'(rd_stb), '0);
        else begin
          e = sb.pop_front();
          check("rd_kind", CW'(e.is_rd), CW'(1));
          check("rd_stb", CW'(rd_stb), CW'(1) << e.idx);
          check("rd_data", CW'(last_out), CW'(e.data));
        end
      end
      prev_wr = wr_stb;
      prev_rd = rd_stb;
    end else begin
      prev_wr = '0;
      prev_rd = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus tasks. The pins change 1 ns after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic bus_ale(input logic [DW-1:0] a);
    @(posedge clk); #1;
    ale_n  = 1'b0;
    bus_in = a;
    repeat (2) @(posedge clk);
    #1;
    ale_n  = 1'b1;
    bus_in = '0;
    repeat (SS + 3) @(posedge clk);
  endtask

  task automatic bus_write(input string tag, input logic [DW-1:0] a,
                           input logic [DW-1:0] d, input int low);
    int wr0, oe0, err0;
    bit hit;
    hit = (a >= BA) && (a < BA + NR);
    if (hit) begin
      sb.push_back('{is_rd: 1'b0, idx: int'(a) - BA, data: d});
      model_regs[int'(a) - BA] = d;
    end
    wr0 = wr_pulses; oe0 = oe_cycles; err0 = err_pulses;
    @(posedge clk); #1;
    wr_n   = 1'b0;
    bus_in = d;
    repeat (low) @(posedge clk);
    #1;
    wr_n   = 1'b1;
    bus_in = '0;
    repeat (SS + 4) @(posedge clk);
    #1;
    check({tag, "_wr_cnt"}, CW'(wr_pulses - wr0), CW'(hit ? 1 : 0));
    check({tag, "_oe_cnt"}, CW'(oe_cycles - oe0), '0);
    check({tag, "_err_cnt"}, CW'(err_pulses - err0), '0);
    check({tag, "_regs"}, reg_q, model_pack());
  endtask

  task automatic bus_read(input string tag, input logic [DW-1:0] a,
                          input int low);
    int oe0, rd0, err0, first;
    bit hit;
    hit = (a >= BA) && (a < BA + NR);
    if (hit) sb.push_back('{is_rd: 1'b1, idx: int'(a) - BA,
                           data: stat_val(int'(a) - BA)});
    oe0 = oe_cycles; rd0 = rd_pulses; err0 = err_pulses; first = 0;
    @(posedge clk); #1;
    rd_n = 1'b0;
    // The k-th sample is taken 1 ns after the k-th rising edge that follows
    // the fall of the pin.
    for (int k = 1; k <= low + SS + 5; k++) begin
      @(posedge clk); #1;
      if (bus_oe && first == 0) first = k;
      if (k == low) rd_n = 1'b1;
    end
    check({tag, "_lat"}, CW'(first), CW'(hit ? SS + 1 : 0));
    check({tag, "_oe_cnt"}, CW'(oe_cycles - oe0), CW'(hit ? low : 0));
    check({tag, "_rd_cnt"}, CW'(rd_pulses - rd0), CW'(hit ? 1 : 0));
    check({tag, "_err_cnt"}, CW'(err_pulses - err0), '0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #(68 * 20000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int err0, rd0, oe0, exp_err;
    exp_err = 0;
    reset_n = 1'b0;
    ale_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    bus_in = '0;
    for (int i = 0; i < NR; i++) begin
      status_in[i*DW +: DW] = stat_val(i);
      model_regs[i] = '0;
    end

    #5;
    check("rst_regs", reg_q, '0);
    check("rst_outs", CW'({bus_out, bus_oe, wr_stb, rd_stb, bus_err}), '0);
    #200;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic write to the first register
    bus_ale(8'h10);
    bus_write("wr_base", 8'h10, 8'hE5, 2);

    // Read status 2, then the same read again without a new ALE
    bus_ale(8'h12);
    bus_read("rd_s2", 8'h12, 1);
    bus_read("rd_s2_again", 8'h12, 3);

    // Out-of-range write above the window, read below the window
    bus_ale(8'h30);
    bus_write("wr_miss", 8'h30, 8'hFF, 2);
    bus_ale(8'h05);
    bus_read("rd_miss", 8'h05, 2);

    // Upper boundary: last register in range, then the first address past it
    bus_ale(8'h1F);
    bus_write("wr_top", 8'h1F, 8'h3C, 2);
    bus_ale(8'h20);
    bus_write("wr_past", 8'h20, 8'h81, 2);

    // rd_n falls during a write: one error pulse, no commit, no drive
    bus_ale(8'h11);
    err0 = err_pulses; oe0 = oe_cycles;
    @(posedge clk); #1;
    wr_n = 1'b0; bus_in = 8'h77;
    repeat (4) @(posedge clk);
    #1 rd_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr_n = 1'b1; rd_n = 1'b1; bus_in = '0;
    repeat (SS + 4) @(posedge clk);
    #1;
    exp_err++;
    check("coll_err", CW'(err_pulses - err0), CW'(1));
    check("coll_oe", CW'(oe_cycles - oe0), '0);
    check("coll_regs", reg_q, model_pack());
    bus_write("wr_after_coll", 8'h11, 8'h77, 2);

    // Long read of 40 cycles
    bus_ale(8'h12);
`ifdef MCU_BUS_TIMEOUT_EN
    err0 = err_pulses; rd0 = rd_pulses;
    @(posedge clk); #1;
    rd_n = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("tmo_oe_dropped", CW'(bus_oe), '0);
    check("tmo_err", CW'(err_pulses - err0), CW'(1));
    repeat (10) @(posedge clk);
    #1 rd_n = 1'b1;
    repeat (SS + 5) @(posedge clk);
    #1;
    exp_err++;
    check("tmo_err_once", CW'(err_pulses - err0), CW'(1));
    check("tmo_no_rd_stb", CW'(rd_pulses - rd0), '0);
`else
    bus_read("rd_long", 8'h12, 40);
`endif

    // Reset while a write strobe is low
    bus_ale(8'h10);
    @(posedge clk); #1;
    wr_n = 1'b0; bus_in = 8'h99;
    repeat (4) @(posedge clk);
    #10;
    check("pre_rst_regs", reg_q, model_pack());
    reset_n = 1'b0;
    #1;
    check("rst_wr_regs", reg_q, '0);
    check("rst_wr_outs", CW'({bus_out, bus_oe, wr_stb, rd_stb, bus_err}), '0);
    wr_n = 1'b1; bus_in = '0;
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    bus_ale(8'h13);
    bus_write("wr_after_rst", 8'h13, 8'hA1, 2);

    // Reset while bus_oe is driving
    bus_ale(8'h12);
    @(posedge clk); #1;
    rd_n = 1'b0;
    repeat (5) @(posedge clk);
    #10;
    check("pre_rst_oe", CW'({bus_oe, bus_out}), CW'({1'b1, 8'h5A}));
    reset_n = 1'b0;
    #1;
    check("rst_rd_outs", CW'({bus_out, bus_oe, wr_stb, rd_stb, bus_err}), '0);
    check("rst_rd_regs", reg_q, '0);
    rd_n = 1'b1;
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    bus_ale(8'h14);
    bus_write("wr_after_rst2", 8'h14, 8'h6B, 3);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", CW'(sb.size()), '0);
    check("err_total", CW'(err_pulses), CW'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_bus_regs.md
Name: mcu_bus_regs

Overview:
- Parametrised slave for the MCU multiplexed ALE/RD/WR parallel bus.
- Synchronises the asynchronous strobes and latches the address during ALE.
- Commits writes into a register bank of NUM_REGS and serves reads from per-register status inputs.
- Sits between the top-level bus pins (tristate handled in top) and the motor, kicker and radio blocks. It replaces the fixed 8-bit decoding with configurable width, depth and base address, plus per-register strobes.

Parameters:
DATA_W, 8, bus data/address width in bits
NUM_REGS, 16, number of registers decoded (1..2^DATA_W)
BASE_ADDR, 0, first decoded address
SYNC_STAGES, 2, synchroniser flops on ale_n/rd_n/wr_n/bus_in (>=2)
TIMEOUT, 255, max cycles a strobe may stay low (used only with MCU_BUS_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ale_n  in  1  address latch enable, active low
rd_n  in  1  read strobe, active low
wr_n  in  1  write strobe, active low
bus_in  in  DATA_W  bus pins as sampled from the pad
bus_out  out  DATA_W  read data to drive onto the bus
bus_oe  out  1  drive enable for bus_out (top builds the tristate)
reg_q  out  NUM_REGS*DATA_W  register bank contents, reg i at [i*DATA_W +: DATA_W]
status_in  in  NUM_REGS*DATA_W  read-back value per register
wr_stb  out  NUM_REGS  one-cycle pulse on the register just written
rd_stb  out  NUM_REGS  one-cycle pulse when a register read completes (clear-on-read hooks)
bus_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low.
  - On reset: reg_q=0, bus_out=0, bus_oe=0, wr_stb=0, rd_stb=0, bus_err=0, latched address=0, state=IDLE. All take effect immediately, without a clock.
- Synchronisation: ale_n, rd_n, wr_n and bus_in pass through SYNC_STAGES flops each, so data stays aligned with its strobe. The flops reset to strobes=1 and bus=0. All logic below uses the synced versions.
- Address phase:
  - While synced ale_n=0, addr_hold tracks synced bus_in every cycle.
  - On synced ale_n 0->1, addr_hold freezes. Data vanishes at ALE release, so only the held value is used.
  - Range check: hit = BASE_ADDR <= addr < BASE_ADDR+NUM_REGS; idx = addr-BASE_ADDR.
- States:
  - IDLE -> ADDR on ale_n falling.
  - ADDR -> IDLE on ale_n rising.
  - IDLE -> WRITE on wr_n falling.
  - IDLE -> READ on rd_n falling.
  - WRITE -> IDLE on wr_n rising.
  - READ -> IDLE on rd_n rising.
- WRITE: data_hold tracks synced bus_in each cycle. On wr_n rising, if hit: reg_q[idx] <= data_hold and wr_stb[idx] is high for exactly the next cycle. Miss: no register change, no strobe.
- READ:
  - On rd_n falling, if hit: bus_out <= status_in[idx] (snapshot, stable for the whole strobe) and bus_oe=1 from the next cycle until rd_n rising.
  - On rd_n rising: bus_oe=0 in the same edge, and rd_stb[idx] pulses one cycle.
  - Miss: bus_oe stays 0, no rd_stb.
  - Latency: bus_oe asserts SYNC_STAGES+1 cycles after the pin falls.
- Protocol errors (bus_err pulses one cycle in each case):
  - rd_n and wr_n both low simultaneously. The transaction is aborted: no write commit, bus_oe=0, and the state machine waits in IDLE until both strobes are high.
  - ale_n low while in READ/WRITE: same abort.
- Back-to-back transactions with no gap cycles in IDLE are legal.
- The address persists: a second read or write without a new ALE reuses the last address.
- Registers are not self-clearing. wr_stb and rd_stb never assert for more than one cycle per transaction.

Optional Feature:
- MCU_BUS_TIMEOUT_EN defined: a counter (width clog2(TIMEOUT+1)) runs while state is READ, WRITE or ADDR. When it reaches TIMEOUT:
  - bus_err pulses and bus_oe drops.
  - A pending write is discarded.
  - The state goes to IDLE, which re-arms only after all strobes are high.
- Undefined: no counter. A stuck strobe holds the state indefinitely; there is no timeout error.

Test Plan:
- BASE_ADDR=0x10, 68 ns clock. ALE 136 ns with 0x10, then wr_n 136 ns with 0xE5 -> reg_q[0]=0xE5; wr_stb=0x0001 for exactly one cycle; bus_oe never asserted.
- status_in[2]=0x5A. ALE 0x12, rd_n low 68 ns -> bus_oe=1 from SYNC_STAGES+1 cycles after the fall until rd_n rises, bus_out=0x5A; rd_stb[2] one pulse. Repeat the read without ALE -> same result.
- Write to 0x30 (out of range) with data 0xFF -> reg_q unchanged, no wr_stb, no bus_err. Read 0x05 -> bus_oe stays 0.
- Drive rd_n and wr_n low together during a write of 0x77 to 0x11 -> bus_err one pulse, reg_q[1] unchanged, bus_oe=0. A following clean write works.
- Assert reset_n low mid-WRITE (wr_n low) and mid-READ (bus_oe=1) -> all outputs 0 immediately without a clock edge. After release, a normal write succeeds.
- With MCU_BUS_TIMEOUT_EN and TIMEOUT=20: hold rd_n low for 40 cycles -> bus_err at cycle 20, bus_oe=0; no rd_stb on release. Without the macro -> bus_oe held for all 40 cycles, no bus_err.
